// File: rtl/bit_reverse_ctrl.sv
// bit_reverse_ctrl
//   Sequencer between a UART RX, the bit-reversal message RAM and a UART TX.
//   Collects '0'/'1' characters into RAM write slots 0..MSG_BITS-1. Once a
//   message is complete it walks the RAM read address 0..MSG_LEN-1 and hands
//   each byte to the TX with a one-cycle strobe, then goes back to collecting.
// Ports
//   clk, rst          clock (rising edge), async active-low reset
//   rx_data/new_rx_data  received byte + one-cycle strobe
//   tx_busy           UART TX busy
//   ram_data          registered RAM read data (1 cycle after ram_addr)
//   ram_wr/ram_bit/ram_wr_idx  RAM write strobe, bit value, write slot
//   ram_addr          RAM read address
//   tx_data/new_tx_data  byte to send + one-cycle start strobe
//   rx_drop           pulse: received char discarded
//   msg_done          pulse: message fully handed to TX
module bit_reverse_ctrl #(
  parameter int unsigned MSG_BITS = 8,
  parameter int unsigned MSG_LEN  = 10,
  parameter logic [7:0]  CLR_CHAR = 8'h63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  input  logic       tx_busy,
  input  logic [7:0] ram_data,
  output logic       ram_wr,
  output logic       ram_bit,
  output logic [3:0] ram_wr_idx,
  output logic [3:0] ram_addr,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  output logic       rx_drop,
  output logic       msg_done
);

  localparam logic [3:0] LAST_WR = 4'(MSG_BITS - 1);
  localparam logic [3:0] LAST_RD = 4'(MSG_LEN - 1);

  typedef enum logic [1:0] {COLLECT, LOAD, SEND, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] wr_idx_q, wr_idx_d;
  logic [3:0] rd_idx_q, rd_idx_d;
  // Set in the ram_wr cycle of the last entry: the RAM captures it at the
  // next edge, which is also when we leave COLLECT.
  logic       full_q, full_d;

  logic       ram_wr_q, ram_wr_d;
  logic       ram_bit_q, ram_bit_d;
  logic [3:0] ram_wr_idx_q, ram_wr_idx_d;
  logic [3:0] ram_addr_q, ram_addr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       new_tx_q, new_tx_d;
  logic       rx_drop_q, rx_drop_d;
  logic       msg_done_q, msg_done_d;

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    full_d       = full_q;
    ram_wr_d     = 1'b0;
    ram_bit_d    = ram_bit_q;
    ram_wr_idx_d = ram_wr_idx_q;
    ram_addr_d   = ram_addr_q;
    tx_data_d    = tx_data_q;
    new_tx_d     = 1'b0;
    rx_drop_d    = 1'b0;
    msg_done_d   = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (full_q) begin
          // Message complete; anything arriving now belongs to the print.
          full_d  = 1'b0;
          state_d = LOAD;
          if (new_rx_data) rx_drop_d = 1'b1;
        end else if (new_rx_data) begin
          if (rx_data == 8'h30 || rx_data == 8'h31) begin
            ram_wr_d     = 1'b1;
            ram_bit_d    = rx_data[0];
            ram_wr_idx_d = wr_idx_q;
            if (wr_idx_q == LAST_WR) begin
              wr_idx_d = '0;
              full_d   = 1'b1;
            end else begin
              wr_idx_d = wr_idx_q + 4'd1;
            end
          end else if (rx_data == CLR_CHAR) begin
            wr_idx_d = '0;
          end else begin
            rx_drop_d = 1'b1;
          end
        end
      end
      LOAD: begin
        ram_addr_d = rd_idx_q;
        state_d    = SEND;
        if (new_rx_data) rx_drop_d = 1'b1;
      end
      SEND: begin
        if (new_rx_data) rx_drop_d = 1'b1;
        if (!tx_busy) begin
          tx_data_d = ram_data;
          new_tx_d  = 1'b1;
          if (rd_idx_q == LAST_RD) begin
            state_d = DONE;
          end else begin
            rd_idx_d   = rd_idx_q + 4'd1;
            ram_addr_d = rd_idx_q + 4'd1;
            state_d    = LOAD;
          end
        end
      end
      DONE: begin
        msg_done_d = 1'b1;
        rd_idx_d   = '0;
        ram_addr_d = '0;
        state_d    = COLLECT;
        if (new_rx_data) rx_drop_d = 1'b1;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= COLLECT;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      full_q       <= 1'b0;
      ram_wr_q     <= 1'b0;
      ram_bit_q    <= 1'b0;
      ram_wr_idx_q <= '0;
      ram_addr_q   <= '0;
      tx_data_q    <= '0;
      new_tx_q     <= 1'b0;
      rx_drop_q    <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      full_q       <= full_d;
      ram_wr_q     <= ram_wr_d;
      ram_bit_q    <= ram_bit_d;
      ram_wr_idx_q <= ram_wr_idx_d;
      ram_addr_q   <= ram_addr_d;
      tx_data_q    <= tx_data_d;
      new_tx_q     <= new_tx_d;
      rx_drop_q    <= rx_drop_d;
      msg_done_q   <= msg_done_d;
    end
  end

  assign ram_wr      = ram_wr_q;
  assign ram_bit     = ram_bit_q;
  assign ram_wr_idx  = ram_wr_idx_q;
  assign ram_addr    = ram_addr_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign rx_drop     = rx_drop_q;
  assign msg_done    = msg_done_q;

endmodule
